tone_decoder: RTL and testbench
===============================

# tone_decoder

Listens to a one-bit square-wave tone line, the same waveform the alarm buzzer output produces, and identifies which musical note is playing. It measures the half-period between edges, classifies it against the note half-period constants, and debounces over several consecutive half-periods. It then reports note onsets, note changes and silence. It sits beside the alarm block as a loop-back checker and melody follower, for example driving a note display or self-test of the buzzer path.

## Interface
- `TOL`, default 16: classification tolerance in clock cycles, ± around each note constant.
- `MATCH_N`, default 3: consecutive in-tolerance half-periods of the same note required before reporting it.
- `SILENCE_CYC`, default 4095: edge-free cycles after which the line is declared silent. Must exceed (largest note constant + TOL + 1).
- `clk`, input, 1: system clock.
- `resetn`, input, 1: asynchronous, active-low reset.
- `tone_in`, input, 1: square-wave line, asynchronous to `clk`.
- `note`, output, 3: current note code. 0 = silence; 1..7 = C, D, E, F, G, A, B.
- `note_valid`, output, 1: one-cycle pulse whenever `note` changes value.
- `tone_on`, output, 1: high when `note` != 0.
- `note_cnt`, output, 8: count of note onsets (transitions into any nonzero `note`); wraps 255→0.

## Operation
- `tone_in` passes through a 2-flop synchronizer, then an edge detector. Both rising and falling edges count as edges.
- Half-period counter `hp` (12 bits):
  - Cleared to 0 in every edge cycle.
  - Otherwise increments each cycle, saturating at `SILENCE_CYC`.
- Armed flag:
  - Cleared by reset and by silence.
  - The first edge while unarmed only sets armed and clears `hp`; no classification happens on that edge.
- Classification, on an edge while armed:
  - Measured value M = `hp` + 1 − 1 = `hp`. This is the generator's count constant, because the generator toggles every (constant+1) cycles.
  - Note k matches if |M − K_k| ≤ `TOL`, where K = C 1915, D 1706, E 1519, F 1432, G 1278, A 1136, B 1014.
  - Windows do not overlap at TOL ≤ 38. At most one note matches; if windows did overlap, the lowest code would win.
  - If M = `SILENCE_CYC` (saturated), the edge is treated as an unarmed first edge.
- Debounce state: candidate `cand` (3 bits) and run counter `run` (0..`MATCH_N`).
  - Match k with k == `cand`: `run` increments, saturating at `MATCH_N`.
  - Match k with k != `cand`: `cand` ← k, `run` ← 1.
  - No match: `cand` ← 0, `run` ← 0. `note` holds its value.
  - When `run` reaches `MATCH_N` and `cand` != `note`: `note` ← `cand` and `note_valid` pulses. If the old `note` was 0, `note_cnt` increments.
- Silence:
  - Fires in the cycle `hp` first reaches `SILENCE_CYC`.
  - Clears armed, `cand` and `run`.
  - If `note` != 0: `note` ← 0 and `note_valid` pulses.
  - `note_cnt` is unchanged.
- A note repeated after a gap (G, silence, G) produces two onsets.
- Reset values: `note` = 0, `note_valid` = 0, `tone_on` = 0, `note_cnt` = 0. Armed = 0, `hp` = 0, `cand` = 0, `run` = 0.

## Timing
- Pin-to-edge latency: 3 `clk` cycles (2 synchronizer flops plus edge register). The latency is constant, so measured half-periods are exact.
- `note`, `note_valid`, `tone_on` and `note_cnt` update 1 cycle after the qualifying edge-detect cycle. All are registered outputs.
- Minimum time to first report after tone start: (`MATCH_N` + 1) edges, i.e. about 4 half-periods at default.
- Silence is reported `SILENCE_CYC` + 1 cycles after the last detected edge.
- Simultaneous events:
  - An edge in the same cycle `hp` would reach `SILENCE_CYC`: the edge wins, `hp` clears and no silence event occurs.
  - An edge while `hp` = `SILENCE_CYC`: treated as a first edge.
- Reset asserted mid-tone clears everything asynchronously. After release, the first edge only arms the decoder.

## Structure
- Shared package holds:
  - The note half-period constants C..B, identical to those used by the alarm ROM.
  - The 3-bit note code enumeration (SILENCE, C..B).
  - The 12-bit period width constant.
- Sub-module `half_period_meter` contains the synchronizer, edge detect, saturating `hp` counter and armed flag. Its outputs are an `edge` strobe, the measured value M with a valid bit, and a `silence` strobe.
- The top level holds the classifier, debounce state and output registers.

## Test plan
- Ideal G: square wave with 1279-cycle half-periods → `note` = 5 with a `note_valid` pulse on the 1-cycle-late edge after the 4th edge; `note_cnt` = 1; `tone_on` = 1.
- Tolerance edges: half-periods M = 1519 + 16 → E (3) reported. M = 1519 + 17 → no match, `note` stays 0.
- Note change: steady D (M = 1706) for 10 edges, then C (M = 1915) → exactly one `note_valid` with `note` = 2, then exactly one with `note` = 1. `note_cnt` = 1.
- Silence and repeat: A tone, then line held low for 5000 cycles, then A again → `note` = 6, then 0 at last edge + 4096 cycles, then 6 again. `note_cnt` = 2 and 3 `note_valid` pulses.
- Glitch rejection: steady B with one half-period of 700 cycles inserted → `note` stays 7 and no `note_valid` pulse.
- Reset mid-tone: drive F and assert `resetn` low for 2 cycles while `note` = 4 → all outputs 0 immediately. After release, F is re-reported after 4 edges and `note_cnt` = 1.

Source files
------------

// File: rtl/tone_decoder_pkg.sv
// tone_decoder shared definitions: note half-period constants,
// note codes and the half-period classifier.
package tone_decoder_pkg;

  localparam int HP_W = 12;

  typedef enum logic [2:0] {
    N_SIL, N_C, N_D, N_E, N_F, N_G, N_A, N_B
  } note_e;

  // Same count constants as the alarm ROM; the generator toggles
  // every (K+1) cycles.
  localparam logic [HP_W-1:0] K_C = 12'd1915;
  localparam logic [HP_W-1:0] K_D = 12'd1706;
  localparam logic [HP_W-1:0] K_E = 12'd1519;
  localparam logic [HP_W-1:0] K_F = 12'd1432;
  localparam logic [HP_W-1:0] K_G = 12'd1278;
  localparam logic [HP_W-1:0] K_A = 12'd1136;
  localparam logic [HP_W-1:0] K_B = 12'd1014;

  function automatic logic [HP_W-1:0] note_k(
    input logic [2:0] code
  );
    logic [HP_W-1:0] k;
    case (code)
      N_C:     k = K_C;
      N_D:     k = K_D;
      N_E:     k = K_E;
      N_F:     k = K_F;
      N_G:     k = K_G;
      N_A:     k = K_A;
      N_B:     k = K_B;
      default: k = '0;
    endcase
    return k;
  endfunction

  // Scans high to low so the lowest matching code wins.
  function automatic logic [2:0] classify(
    input logic [HP_W-1:0] m,
    input logic [HP_W-1:0] tol
  );
    logic [2:0]      r;
    logic [HP_W-1:0] kv;
    logic [HP_W-1:0] d;
    r = N_SIL;
    for (int k = 7; k >= 1; k--) begin
      kv = note_k(3'(k));
      d  = (m >= kv) ? m - kv : kv - m;
      if (d <= tol) r = 3'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_decoder_meter.sv
// half_period_meter: synchronizer, edge detect, saturating
// half-period counter and armed flag.
module half_period_meter
  import tone_decoder_pkg::*;
#(
  parameter int SILENCE_CYC = 4095
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_tone,
  output logic            o_edge,
  output logic            o_m_valid,
  output logic [HP_W-1:0] o_m,
  output logic            o_silence
);

  localparam logic [HP_W-1:0] SIL    = HP_W'(SILENCE_CYC);
  localparam logic [HP_W-1:0] SIL_M1 = HP_W'(SILENCE_CYC - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic            r_edge;
  logic            r_armed;
  logic [HP_W-1:0] r_hp;
  logic            w_sil;

  // Fires in the cycle hp steps onto SIL; an edge wins.
  assign w_sil = !r_edge && (r_hp == SIL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_edge  <= 1'b0;
      r_armed <= 1'b0;
      r_hp    <= '0;
    end else begin
      r_s1   <= i_tone;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 ^ r_s3;
      if (r_edge)
        r_hp <= '0;
      else if (r_hp != SIL)
        r_hp <= r_hp + 1'b1;
      if (r_edge)
        r_armed <= 1'b1;
      else if (w_sil)
        r_armed <= 1'b0;
    end
  end

  assign o_edge    = r_edge;
  assign o_m       = r_hp;
  assign o_m_valid = r_edge && r_armed && (r_hp != SIL);
  assign o_silence = w_sil;

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: classifies measured half-periods into notes,
// debounces them and reports onsets, changes and silence.
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int TOL         = 16,
  parameter int MATCH_N     = 3,
  parameter int SILENCE_CYC = 4095
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tone_in,
  output logic [2:0] note,
  output logic       note_valid,
  output logic       tone_on,
  output logic [7:0] note_cnt
);

  localparam int RW = $clog2(MATCH_N + 1);
  localparam logic [RW-1:0]   RUN_MAX = RW'(MATCH_N);
  localparam logic [HP_W-1:0] TOL_W   = HP_W'(TOL);

  logic            w_edge;
  logic            w_m_valid;
  logic [HP_W-1:0] w_m;
  logic            w_sil;
  logic            w_meas;
  logic [2:0]      w_k;

  logic [2:0]    r_cand;
  logic [RW-1:0] r_run;
  logic [2:0]    r_note;
  logic          r_vld;
  logic          r_on;
  logic [7:0]    r_cnt;

  logic [2:0]    w_cand_n;
  logic [RW-1:0] w_run_n;
  logic [2:0]    w_note_n;
  logic          w_vld_n;
  logic [7:0]    w_cnt_n;

  half_period_meter #(
    .SILENCE_CYC(SILENCE_CYC)
  ) u_meter (
    .clk      (clk),
    .rst_n    (resetn),
    .i_tone   (tone_in),
    .o_edge   (w_edge),
    .o_m_valid(w_m_valid),
    .o_m      (w_m),
    .o_silence(w_sil)
  );

  assign w_meas = w_edge & w_m_valid;
  assign w_k    = classify(w_m, TOL_W);

  always_comb begin
    w_cand_n = r_cand;
    w_run_n  = r_run;
    w_note_n = r_note;
    w_vld_n  = 1'b0;
    w_cnt_n  = r_cnt;
    unique case (1'b1)
      w_sil: begin
        w_cand_n = N_SIL;
        w_run_n  = '0;
        if (r_note != N_SIL) begin
          w_note_n = N_SIL;
          w_vld_n  = 1'b1;
        end
      end
      w_meas: begin
        if (w_k == N_SIL) begin
          w_cand_n = N_SIL;
          w_run_n  = '0;
        end else begin
          if (w_k == r_cand) begin
            w_run_n = (r_run == RUN_MAX) ?
                      RUN_MAX : r_run + 1'b1;
          end else begin
            w_cand_n = w_k;
            w_run_n  = RW'(1);
          end
          if (w_run_n == RUN_MAX &&
              w_cand_n != r_note) begin
            w_note_n = w_cand_n;
            w_vld_n  = 1'b1;
            if (r_note == N_SIL)
              w_cnt_n = r_cnt + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cand <= '0;
      r_run  <= '0;
      r_note <= '0;
      r_vld  <= 1'b0;
      r_on   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cand <= w_cand_n;
      r_run  <= w_run_n;
      r_note <= w_note_n;
      r_vld  <= w_vld_n;
      r_on   <= (w_note_n != N_SIL);
      r_cnt  <= w_cnt_n;
    end
  end

  assign note       = r_note;
  assign note_valid = r_vld;
  assign tone_on    = r_on;
  assign note_cnt   = r_cnt;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: timestamp-based note model with per-cycle
// compare plus directed literal checks.
module tb_tone_decoder;

  localparam int SIL = 4095;
  localparam int TOL = 16;
  localparam int MN  = 3;
  localparam int LAT = 3;

  logic       clk     = 1'b0;
  logic       resetn  = 1'b1;
  logic       tone_in = 1'b0;
  logic [2:0] note;
  logic       note_valid;
  logic       tone_on;
  logic [7:0] note_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int n_print = 0;
  int vcount  = 0;

  int K [8] = '{0, 1915, 1706, 1519, 1432, 1278, 1136, 1014};

  int          cyc   = 0;
  int          last  = 0;
  int          armed = 0;
  int          cand  = 0;
  int          run   = 0;
  int          gap   = 0;
  int          k     = 0;
  logic [2:0]  mnote = '0;
  logic [7:0]  mcnt  = '0;
  logic        prev  = 1'b0;
  logic        mv    = 1'b0;
  logic [11:0] dl [4];

  always #5 clk = ~clk;

  tone_decoder dut (
    .clk       (clk),
    .resetn    (resetn),
    .tone_in   (tone_in),
    .note      (note),
    .note_valid(note_valid),
    .tone_on   (tone_on),
    .note_cnt  (note_cnt)
  );

  function automatic int nclass(int m);
    int d;
    for (int i = 1; i <= 7; i++) begin
      d = m - K[i];
      if (d < 0) d = -d;
      if (d <= TOL) return i;
    end
    return 0;
  endfunction

  task automatic check(string name, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, got, exp);
  endtask

  // Model: edges by pin timestamp, M = gap - 1.
  initial begin
    foreach (dl[i]) dl[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        armed = 0; cand = 0; run = 0;
        mnote = '0; mcnt = '0; prev = 1'b0;
        last = cyc;
        foreach (dl[i]) dl[i] = '0;
      end else begin
        mv = 1'b0;
        if (tone_in != prev) begin
          prev = tone_in;
          gap  = cyc - last;
          last = cyc;
          if (armed == 0 || gap - 1 >= SIL) begin
            armed = 1;
          end else begin
            k = nclass(gap - 1);
            if (k == 0) begin
              cand = 0; run = 0;
            end else begin
              if (k == cand) run = (run < MN) ? run + 1 : MN;
              else begin cand = k; run = 1; end
              if (run == MN && cand != int'(mnote)) begin
                if (mnote == 0) mcnt = mcnt + 8'd1;
                mnote = 3'(cand);
                mv = 1'b1;
              end
            end
          end
        end else if (cyc - last == SIL) begin
          armed = 0; cand = 0; run = 0;
          if (mnote != 0) begin
            mnote = '0;
            mv = 1'b1;
          end
        end
        for (int i = LAT; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = {mnote, mv, mcnt};
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    logic [11:0] e;
    logic        eon;
    forever begin
      @(negedge clk);
      e   = resetn ? dl[LAT] : 12'h000;
      eon = (e[11:9] != 3'd0);
      n_total++;
      if ({note, note_valid, note_cnt} == e && tone_on == eon)
        n_pass++;
      else if (n_print < 20) begin
        n_print++;
        $display("FAIL cycle t=%0t got n=%0d v=%0d on=%0d c=%0d exp n=%0d v=%0d on=%0d c=%0d",
                 $time, note, note_valid, tone_on, note_cnt,
                 e[11:9], e[8], eon, e[7:0]);
      end
      if (note_valid) vcount++;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tgl(int h, int n);
    repeat (n) begin
      tone_in = ~tone_in;
      wait_cyc(h);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn  = 1'b0;
    tone_in = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(3);
    vcount = 0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    wait_cyc(3);
    check("rst_note", note, 0);
    check("rst_valid", note_valid, 0);
    check("rst_on", tone_on, 0);
    check("rst_cnt", note_cnt, 0);
    resetn = 1'b1;
    wait_cyc(3);
    vcount = 0;

    // Ideal G
    tgl(1279, 4);
    check("G_note", note, 5);
    check("G_model", mnote, 5);
    check("G_on", tone_on, 1);
    check("G_cnt", note_cnt, 1);
    check("G_pulses", vcount, 1);

    // Tolerance window edges of E
    do_reset();
    tgl(1536, 4);
    check("E_tol16", note, 3);
    do_reset();
    tgl(1537, 4);
    check("E_tol17", note, 0);
    check("E_tol17_pulses", vcount, 0);

    // D then C
    do_reset();
    tgl(1707, 10);
    check("D_note", note, 2);
    tgl(1916, 4);
    check("C_note", note, 1);
    check("DC_cnt", note_cnt, 1);
    check("DC_pulses", vcount, 2);

    // A, silence, A
    do_reset();
    tgl(1137, 4);
    check("A1_note", note, 6);
    wait_cyc(5000);
    check("sil_note", note, 0);
    check("sil_on", tone_on, 0);
    tgl(1137, 4);
    check("A2_note", note, 6);
    check("A2_cnt", note_cnt, 2);
    check("A2_pulses", vcount, 3);

    // B with one glitch half-period
    do_reset();
    tgl(1015, 4);
    tgl(700, 1);
    tgl(1015, 4);
    check("B_note", note, 7);
    check("B_pulses", vcount, 1);

    // Reset in the middle of F
    do_reset();
    tgl(1433, 4);
    check("F1_note", note, 4);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("Frst_note", note, 0);
    check("Frst_on", tone_on, 0);
    check("Frst_cnt", note_cnt, 0);
    wait_cyc(2);
    resetn = 1'b1;
    vcount = 0;
    tgl(1433, 5);
    check("F2_note", note, 4);
    check("F2_cnt", note_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
